// File: rtl/pll_supervisor_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL lock supervisor.
//   state_e       one-hot FSM state encodings
//   STATUS_W      width of the saturating status counters
//   IDX_RESET/RUN bit positions of the RESET and RUN state flops
//   cnt_width()   width of the shared down-counter for the given cycle counts
package pll_sup_pkg;

    localparam int STATUS_W  = 8;
    localparam int IDX_RESET = 0;
    localparam int IDX_RUN   = 3;

    typedef enum logic [3:0] {
        ST_RESET = 4'b0001,
        ST_WAIT  = 4'b0010,
        ST_QUAL  = 4'b0100,
        ST_RUN   = 4'b1000
    } state_e;

    // Largest reload value needs $clog2(max) bits; one extra keeps headroom
    // for the exact power-of-two case.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: PLL-facing and status signals of the lock supervisor.
//   locked       PLL LOCK (asynchronous)
//   rearm        single-cycle request to re-reset the PLL
//   pll_resetb   PLL RESETB, active low
//   ready        PLL locked and qualified
//   retry_count  saturating lock-timeout count
//   loss_count   saturating lock-loss count
// modport slave is the supervisor side, master is the environment side.
interface pll_supervisor_if;
    import pll_sup_pkg::*;

    logic                locked;
    logic                rearm;
    logic                pll_resetb;
    logic                ready;
    logic [STATUS_W-1:0] retry_count;
    logic [STATUS_W-1:0] loss_count;

    modport master (
        output locked, rearm,
        input  pll_resetb, ready, retry_count, loss_count
    );

    modport slave (
        input  locked, rearm,
        output pll_resetb, ready, retry_count, loss_count
    );

endinterface

// File: rtl/pll_supervisor_sync2.sv
// sync2: generic two-flop synchronizer with synchronous active-low reset.
//   clk_i   destination clock
//   rst_ni  synchronous reset, active low (flops clear to 0)
//   d_i     asynchronous input
//   q_o     synchronized output, two edges of latency
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: drives SB_PLL40_CORE RESETB, watches LOCK, re-arms the PLL
// on lock timeout or lock loss, and raises ready after a stable-lock window.
//   clock_in  reference clock (same net as PLL REFERENCECLK)
//   resetn    synchronous active-low reset
//   bus       pll_supervisor_if.slave (locked, rearm in; pll_resetb, ready,
//             retry_count, loss_count out)
// Define PLL_SUP_STATUS_EN to build the saturating retry/loss counters;
// otherwise both status outputs read 0 and the FSM is unchanged.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic             clock_in,
    input  logic             resetn,
    pll_supervisor_if.slave  bus
);

    localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    // Each state is occupied for N cycles by loading N-1 on entry and
    // leaving on the cycle the counter reads zero.
    localparam logic [CW-1:0] RST_LD = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] QU_LD  = CW'(STABLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    st_bits;
    logic          lock_s;
    logic          cnt_zero;

    sync2 #(.W(1)) u_lock_sync (
        .clk_i  (clock_in),
        .rst_ni (resetn),
        .d_i    (bus.locked),
        .q_o    (lock_s)
    );

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clock_in) begin
        if (!resetn) begin
            state_q <= ST_RESET;
            cnt_q   <= RST_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.rearm) begin
            // Overrides every other transition, including a restart of an
            // in-progress RESET hold.
            state_d = ST_RESET;
            cnt_d   = RST_LD;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_zero) begin
                        state_d = ST_WAIT;
                        cnt_d   = TO_LD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_WAIT: begin
                    // Lock is tested first so it wins over a same-cycle timeout.
                    if (lock_s) begin
                        state_d = ST_QUAL;
                        cnt_d   = QU_LD;
                    end else if (cnt_zero) begin
                        state_d = ST_RESET;
                        cnt_d   = RST_LD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_QUAL: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = TO_LD;
                    end else if (cnt_zero) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        cnt_d   = RST_LD;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LD;
                end
            endcase
        end
    end

    // Outputs come straight off single state flops so they cannot glitch.
    assign st_bits        = state_q;
    assign bus.pll_resetb = ~st_bits[IDX_RESET];
    assign bus.ready      = st_bits[IDX_RUN];

`ifdef PLL_SUP_STATUS_EN
    logic                timeout_ev;
    logic                loss_ev;
    logic [STATUS_W-1:0] retry_q;
    logic [STATUS_W-1:0] loss_q;

    // rearm masks both events: it forces RESET without being counted.
    assign timeout_ev = !bus.rearm && (state_q == ST_WAIT) && !lock_s && cnt_zero;
    assign loss_ev    = !bus.rearm && (state_q == ST_RUN)  && !lock_s;

    always_ff @(posedge clock_in) begin
        if (!resetn) begin
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            if (timeout_ev && (retry_q != '1)) retry_q <= retry_q + STATUS_W'(1);
            if (loss_ev    && (loss_q  != '1)) loss_q  <= loss_q  + STATUS_W'(1);
        end
    end

    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;
`else
    assign bus.retry_count = '0;
    assign bus.loss_count  = '0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
module tb_pll_supervisor;

`ifdef PLL_SUP_STATUS_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    pll_supervisor_if bus();

    pll_supervisor #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8)
    ) dut (
        .clock_in (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic int ex(input int v);
        return ST_EN ? v : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Intervals (including the current one) during which pll_resetb == lvl.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (bus.pll_resetb === lvl && n < 1000) begin
            n++;
            tick();
        end
    endtask

    // Edges until ready == lvl; flags any pll_resetb low seen on the way.
    task automatic edges_to_ready(input logic lvl, output int n, output bit rb_low);
        n = 0;
        rb_low = 1'b0;
        while (bus.ready !== lvl && n < 200) begin
            tick();
            n++;
            if (bus.pll_resetb !== 1'b1) rb_low = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit rbl;

        resetn     = 1'b0;
        bus.locked = 1'b0;
        bus.rearm  = 1'b0;
        repeat (3) tick();
        chk("rst_resetb", bus.pll_resetb, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_retry", bus.retry_count, 0);
        chk("rst_loss", bus.loss_count, 0);

        // Timeout scenario
        resetn = 1'b1;
        run_len(1'b0, n); chk("to_low1", n, 4);
        run_len(1'b1, n); chk("to_high1", n, 32);
        chk("to_retry1", bus.retry_count, ex(1));
        run_len(1'b0, n); chk("to_low2", n, 4);
        run_len(1'b1, n); chk("to_high2", n, 32);
        chk("to_retry2", bus.retry_count, ex(2));
        for (int i = 0; i < 298; i++) begin
            run_len(1'b0, n);
            run_len(1'b1, n);
        end
        chk("to_high300", n, 32);
        chk("to_retry_sat", bus.retry_count, ex(255));
        chk("to_ready", bus.ready, 0);

        // resetn clears the status counters
        resetn = 1'b0;
        repeat (2) tick();
        chk("rst2_retry", bus.retry_count, 0);
        chk("rst2_resetb", bus.pll_resetb, 0);
        resetn = 1'b1;
        run_len(1'b0, n); chk("rst2_low", n, 4);

        // Lock 10 cycles into WAIT_LOCK
        repeat (10) tick();
        bus.locked = 1'b1;
        edges_to_ready(1'b1, n, rbl);
        chk("lk_edges", n, 11);
        chk("lk_rb_low", rbl, 0);
        chk("lk_retry", bus.retry_count, 0);
        chk("lk_loss", bus.loss_count, 0);

        // Lock loss in RUN, then re-qualification
        bus.locked = 1'b0;
        edges_to_ready(1'b0, n, rbl);
        chk("loss_edges", n, 3);
        chk("loss_resetb", bus.pll_resetb, 0);
        chk("loss_cnt", bus.loss_count, ex(1));
        run_len(1'b0, n); chk("loss_low", n, 4);
        bus.locked = 1'b1;
        edges_to_ready(1'b1, n, rbl);
        chk("requal_edges", n, 11);
        chk("requal_rb_low", rbl, 0);

        // rearm in RUN
        bus.rearm  = 1'b1;
        bus.locked = 1'b0;
        tick();
        bus.rearm  = 1'b0;
        chk("rearm_ready", bus.ready, 0);
        chk("rearm_resetb", bus.pll_resetb, 0);
        chk("rearm_loss", bus.loss_count, ex(1));
        // rearm while in RESET restarts the hold
        tick();
        bus.rearm = 1'b1;
        tick();
        bus.rearm = 1'b0;
        run_len(1'b0, n); chk("rearm_restart_low", n, 4);

        // Lock and timeout in the same cycle: lock wins
        repeat (29) tick();
        bus.locked = 1'b1;
        edges_to_ready(1'b1, n, rbl);
        chk("tie_edges", n, 11);
        chk("tie_rb_low", rbl, 0);
        chk("tie_retry", bus.retry_count, 0);

        // Lock glitch during QUALIFY
        bus.rearm  = 1'b1;
        bus.locked = 1'b0;
        tick();
        bus.rearm  = 1'b0;
        run_len(1'b0, n); chk("gl_low", n, 4);
        bus.locked = 1'b1;
        repeat (5) tick();
        bus.locked = 1'b0;
        rbl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.ready !== 1'b0 || bus.pll_resetb !== 1'b1) rbl = 1'b1;
        end
        chk("gl_hold", rbl, 0);
        bus.locked = 1'b1;
        edges_to_ready(1'b1, n, rbl);
        chk("gl_edges", n, 11);
        chk("gl_rb_low", rbl, 0);

        // rearm in the same cycle RUN sees the lock drop
        bus.locked = 1'b0;
        tick();
        tick();
        bus.rearm = 1'b1;
        tick();
        bus.rearm = 1'b0;
        chk("rl_ready", bus.ready, 0);
        chk("rl_resetb", bus.pll_resetb, 0);
        chk("rl_loss", bus.loss_count, ex(1));
        run_len(1'b0, n); chk("rl_low", n, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Lock supervisor for the SB_PLL40_CORE PLL wrapper, clocked from the board reference clock that also feeds the PLL's REFERENCECLK. It drives the PLL's active-low RESETB and monitors its asynchronous LOCK output. It re-arms the PLL on lock timeout or lock loss, and asserts `ready` only after lock has been continuously stable for a qualification window. `ready` is the release condition for the reset generator of the PLL output clock domain; it also drives board status LEDs.

## Interface
- `RESET_CYCLES`, 16: cycles `pll_resetb` is held low on each PLL reset (≥1).
- `LOCK_TIMEOUT`, 100000: cycles allowed in WAIT_LOCK before re-arming the PLL (1 ms at 100 MHz, ≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before `ready` (≥1).
- `clock_in`  input  1  reference clock, same net as the PLL REFERENCECLK.
- `resetn`  input  1  synchronous, active-low reset.
- `locked`  input  1  PLL LOCK, asynchronous to `clock_in`.
- `rearm`  input  1  single-cycle request to re-reset the PLL.
- `pll_resetb`  output  1  to PLL RESETB, active low.
- `ready`  output  1  PLL locked and qualified.
- `retry_count`  output  8  saturating count of lock timeouts.
- `loss_count`  output  8  saturating count of lock losses while in RUN.

## Operation
- `locked` passes through a two-flop synchronizer to produce `lock_s`. The FSM uses only `lock_s`.
- FSM is one-hot with states RESET, WAIT_LOCK, QUALIFY and RUN. A single down-counter `cnt` is shared by all states and is reloaded on every state entry.
- `pll_resetb` is 0 only in RESET. `ready` is 1 only in RUN. Both are taken directly from state flops and are glitch-free.
- RESET: hold for exactly `RESET_CYCLES` cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - `lock_s`=1 → QUALIFY.
  - Otherwise, after `LOCK_TIMEOUT` cycles → RESET and `retry_count`+1.
  - If lock and timeout occur in the same cycle, lock wins.
- QUALIFY:
  - `lock_s`=0 → WAIT_LOCK, with the timeout restarted.
  - `STABLE_CYCLES` consecutive high cycles → RUN.
- RUN: `lock_s`=0 → RESET and `loss_count`+1.
- `rearm`=1 forces RESET from any state on the next edge and has priority over every other transition. It does not increment either counter. `rearm` asserted while already in RESET restarts the RESET hold.
- Status counters saturate at 255 and are cleared only by `resetn`.
- Counter width is derived as $clog2 of the largest of the three parameters plus one.

## Timing
- On the first edge with `resetn`=0: state=RESET, `pll_resetb`=0, `ready`=0, counters=0, synchronizer flops=0.
- While `resetn`=0, everything is held at reset values. After release, `pll_resetb` stays low for `RESET_CYCLES` more cycles.
- `locked` rise to `ready` rise: `STABLE_CYCLES`+3 edges. This is 2 synchronizer edges, 1 edge for the WAIT_LOCK exit, and `STABLE_CYCLES` qualify edges.
- `locked` fall in RUN: `ready` falls and `pll_resetb` falls 3 edges later, in the same cycle. `loss_count` increments on that same edge.
- A `locked` glitch shorter than one `clock_in` period may be missed. This is accepted.
- `rearm` sampled high at edge n: `ready`=0 and `pll_resetb`=0 after edge n.

## Configuration
- `PLL_SUP_STATUS_EN` defined: `retry_count` and `loss_count` are implemented as specified.
- `PLL_SUP_STATUS_EN` undefined: both outputs are tied to 8'd0, no counter flops are built, and the FSM is unchanged.

## Structure
- Package `pll_sup_pkg`: state enum (one-hot encodings), the 8-bit status width constant, and a `cnt_width` function.
- Sub-module `sync2`: the generic two-flop synchronizer used for `locked`.

## Test plan
Test parameters: `RESET_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8.

- Reset, then hold `locked`=0 → `pll_resetb` is low for 4 cycles after release, then high for 32 cycles, then low again. `retry_count`=1. After 300 such timeouts, `retry_count` holds at 255.
- Raise `locked` 10 cycles into WAIT_LOCK and hold it → `ready` rises exactly 11 edges later. `pll_resetb` stays 1 and both counters stay 0.
- Pulse `locked` low for 3 cycles during QUALIFY → state returns to WAIT_LOCK and `ready` stays 0. A subsequent stable lock gives `ready` 11 edges after the rise.
- Drop `locked` in RUN → `ready`=0 and `pll_resetb`=0 3 edges later, `loss_count`=1, and re-qualification proceeds normally.
- `rearm` pulse in RUN, and a second `rearm` in the same cycle as a lock drop → RESET is entered in both cases and `loss_count` is unchanged.
- Build without `PLL_SUP_STATUS_EN` and run the timeout scenario → FSM timing is identical and both counters read 0.
